// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for the pipe_MIPS32 unified memory: dbg > mem > if,
// with a fetch starvation override, a registered RAM port and read-data routing.
module mem_port_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 16
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [CW-1:0] stall_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_MEM, OWN_IF} owner_t;

  logic [SW-1:0] starve_cnt;
  logic          starved;
  owner_t        own1, own2;

  logic          sel_en;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  owner_t        sel_own;

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    dbg_gnt = 1'b0;
    mem_gnt = 1'b0;
    if_gnt  = 1'b0;
    if (!rst) begin
      if (dbg_req)                            dbg_gnt = 1'b1;
      else if (if_req && (starved || !mem_req)) if_gnt = 1'b1;
      else if (mem_req)                       mem_gnt = 1'b1;
    end
  end

  assign if_stall = if_req & ~if_gnt;

  always_comb begin
    sel_en    = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_own   = OWN_NONE;
    if (dbg_gnt) begin
      sel_en    = 1'b1;
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
      sel_own   = dbg_we ? OWN_NONE : OWN_DBG;
    end else if (mem_gnt) begin
      sel_en    = 1'b1;
      sel_we    = mem_we;
      sel_addr  = mem_addr;
      sel_wdata = mem_wdata;
      sel_own   = mem_we ? OWN_NONE : OWN_MEM;
    end else if (if_gnt) begin
      sel_en    = 1'b1;
      sel_addr  = if_addr;
      sel_own   = OWN_IF;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      own1       <= OWN_NONE;
      own2       <= OWN_NONE;
      starve_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      ram_en <= sel_en;
      ram_we <= sel_we;
      // Address/data hold their last value on idle cycles to avoid needless toggling.
      if (sel_en) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      own1 <= sel_own;
      own2 <= own1;
      if (if_stall) begin
        if (!starved) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
      if (if_stall && (stall_cnt != {CW{1'b1}})) stall_cnt <= stall_cnt + CW'(1);
    end
  end

  // own2 marks the cycle in which the RAM output belongs to a read.
  assign dbg_rvalid = (own2 == OWN_DBG);
  assign mem_rvalid = (own2 == OWN_MEM);
  assign if_rvalid  = (own2 == OWN_IF);
  assign dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
  assign mem_rdata  = mem_rvalid ? ram_rdata : '0;
  assign if_rdata   = if_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM;
// a second instance with CW=4 exercises stall counter saturation.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          dbg_req, dbg_we, mem_req, mem_we, if_req;
  logic [AW-1:0] dbg_addr, mem_addr, if_addr;
  logic [DW-1:0] dbg_wdata, mem_wdata;
  logic          dbg_gnt, dbg_rvalid, mem_gnt, mem_rvalid, if_gnt, if_rvalid, if_stall;
  logic [DW-1:0] dbg_rdata, mem_rdata, if_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   stall_cnt;

  logic          s_dbg_gnt, s_dbg_rvalid, s_mem_gnt, s_mem_rvalid, s_if_gnt, s_if_rvalid, s_if_stall;
  logic [DW-1:0] s_dbg_rdata, s_mem_rdata, s_if_rdata;
  logic          s_ram_en, s_ram_we;
  logic [AW-1:0] s_ram_addr;
  logic [DW-1:0] s_ram_wdata;
  logic [3:0]    s_stall_cnt;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .CW(16)) dut (
    .clk1(clk1), .rst(rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .CW(4)) u_sat (
    .clk1(clk1), .rst(rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(s_dbg_gnt), .dbg_rvalid(s_dbg_rvalid), .dbg_rdata(s_dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(s_mem_gnt), .mem_rvalid(s_mem_rvalid), .mem_rdata(s_mem_rdata),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(s_if_gnt), .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata), .if_stall(s_if_stall),
    .ram_en(s_ram_en), .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata),
    .ram_rdata(ram_rdata), .stall_cnt(s_stall_cnt)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic clear_reqs();
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    if_req  = 0; if_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_reqs();
    tick(); tick();
    dbg_req = 1; mem_req = 1; if_req = 1;
    #2;
    checks++;
    if ({dbg_gnt, mem_gnt, if_gnt} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt: got %b required 000", {dbg_gnt, mem_gnt, if_gnt});
    end
    tick();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_regs: got en=%b we=%b addr=%h wdata=%h stall=%0d required all 0",
                         ram_en, ram_we, ram_addr, ram_wdata, stall_cnt);
    end
    checks++;
    if ({dbg_rvalid, mem_rvalid, if_rvalid} !== 3'b000 || (dbg_rdata | mem_rdata | if_rdata) !== '0) begin
      errors++; $display("FAIL reset_rvalid: got %b required 000", {dbg_rvalid, mem_rvalid, if_rvalid});
    end
    clear_reqs();
    rst = 0;
    tick();
  endtask

  task automatic test_fetch();
    ram[0] = 32'h2801000a; ram[1] = 32'h28010014; ram[2] = 32'h28010019;
    if_req = 1; if_addr = 0;
    #2;
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt0: got %b required 1", if_gnt); end
    tick();
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'd0) begin
      errors++; $display("FAIL fetch_ram0: got en=%b we=%b addr=%0d required 1 0 0", ram_en, ram_we, ram_addr);
    end
    if_addr = 1;
    #2;
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt1: got %b required 1", if_gnt); end
    tick();
    if_addr = 2;
    #2;
    checks++;
    if (if_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'h2801000a || mem_rdata !== '0) begin
      errors++; $display("FAIL fetch_data0: got gnt=%b rv=%b data=%h mem_rdata=%h required 1 1 2801000a 0",
                         if_gnt, if_rvalid, if_rdata, mem_rdata);
    end
    tick();
    if_req = 0;
    #2;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h28010014) begin
      errors++; $display("FAIL fetch_data1: got rv=%b data=%h required 1 28010014", if_rvalid, if_rdata);
    end
    tick();
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h28010019) begin
      errors++; $display("FAIL fetch_data2: got rv=%b data=%h required 1 28010019", if_rvalid, if_rdata);
    end
    tick();
    checks++;
    if (if_rvalid !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL fetch_end: got rv=%b stall=%0d required 0 0", if_rvalid, stall_cnt);
    end
  endtask

  task automatic test_conflict();
    ram[12] = 32'hfc000000; ram[3] = 32'h12345678;
    if_req = 1; if_addr = 3;
    mem_req = 1; mem_we = 0; mem_addr = 12;
    #2;
    checks++;
    if (mem_gnt !== 1'b1 || if_gnt !== 1'b0 || if_stall !== 1'b1) begin
      errors++; $display("FAIL conflict_gnt: got mem=%b if=%b stall=%b required 1 0 1", mem_gnt, if_gnt, if_stall);
    end
    tick();
    mem_req = 0;
    #2;
    checks++;
    if (if_gnt !== 1'b1 || if_stall !== 1'b0) begin
      errors++; $display("FAIL conflict_if_next: got gnt=%b stall=%b required 1 0", if_gnt, if_stall);
    end
    tick();
    if_req = 0;
    #2;
    checks++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== 32'hfc000000 || if_rvalid !== 1'b0 || if_rdata !== '0) begin
      errors++; $display("FAIL conflict_mem_data: got rv=%b data=%h if_rv=%b required 1 fc000000 0",
                         mem_rvalid, mem_rdata, if_rvalid);
    end
    checks++;
    if (stall_cnt !== 16'd1) begin errors++; $display("FAIL conflict_stall_cnt: got %0d required 1", stall_cnt); end
    tick();
    checks++;
    if (mem_rvalid !== 1'b0 || if_rvalid !== 1'b1 || if_rdata !== 32'h12345678) begin
      errors++; $display("FAIL conflict_if_data: got mem_rv=%b if_rv=%b data=%h required 0 1 12345678",
                         mem_rvalid, if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic exp_if;
    mem_req = 1; mem_we = 0; mem_addr = 12;
    if_req = 1; if_addr = 0;
    for (int i = 0; i < 10; i++) begin
      exp_if = (i == 4) || (i == 9);
      #2;
      checks++;
      if (if_gnt !== exp_if || mem_gnt !== !exp_if || if_stall !== !exp_if) begin
        errors++; $display("FAIL starve_cycle%0d: got if=%b mem=%b stall=%b required if=%b mem=%b",
                           i, if_gnt, mem_gnt, if_stall, exp_if, !exp_if);
      end
      tick();
    end
    clear_reqs();
    tick(); tick();
  endtask

  task automatic test_dbg_priority();
    dbg_req = 1; dbg_we = 1; dbg_addr = 5; dbg_wdata = 32'h00832800;
    mem_req = 1; mem_we = 0; mem_addr = 5;
    if_req = 1; if_addr = 7;
    #2;
    checks++;
    if ({dbg_gnt, mem_gnt, if_gnt} !== 3'b100) begin
      errors++; $display("FAIL dbg_prio_gnt: got %b required 100", {dbg_gnt, mem_gnt, if_gnt});
    end
    tick();
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd5 || ram_wdata !== 32'h00832800) begin
      errors++; $display("FAIL dbg_prio_ram: got en=%b we=%b addr=%0d wdata=%h required 1 1 5 00832800",
                         ram_en, ram_we, ram_addr, ram_wdata);
    end
    dbg_req = 0; dbg_we = 0;
    #2;
    checks++;
    if ({dbg_gnt, mem_gnt, if_gnt} !== 3'b010) begin
      errors++; $display("FAIL dbg_prio_mem_next: got %b required 010", {dbg_gnt, mem_gnt, if_gnt});
    end
    tick();
    mem_req = 0; if_req = 0;
    #2;
    checks++;
    if (dbg_rvalid !== 1'b0 || dbg_rdata !== '0) begin
      errors++; $display("FAIL dbg_write_no_rvalid: got rv=%b data=%h required 0 0", dbg_rvalid, dbg_rdata);
    end
    tick();
    checks++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h00832800) begin
      errors++; $display("FAIL dbg_raw_read: got rv=%b data=%h required 1 00832800", mem_rvalid, mem_rdata);
    end
    tick(); tick();
  endtask

  task automatic test_reset_midflight();
    mem_req = 1; mem_we = 0; mem_addr = 12;
    #2;
    checks++;
    if (mem_gnt !== 1'b1) begin errors++; $display("FAIL midflight_gnt: got %b required 1", mem_gnt); end
    tick();
    mem_req = 0; rst = 1; dbg_req = 1; if_req = 1;
    #2;
    checks++;
    if ({dbg_gnt, mem_gnt, if_gnt} !== 3'b000) begin
      errors++; $display("FAIL midflight_rst_gnt: got %b required 000", {dbg_gnt, mem_gnt, if_gnt});
    end
    tick();
    rst = 0;
    clear_reqs();
    checks++;
    if (ram_en !== 1'b0 || ram_addr !== '0 || mem_rvalid !== 1'b0 || mem_rdata !== '0 || stall_cnt !== '0) begin
      errors++; $display("FAIL midflight_regs: got en=%b addr=%0d rv=%b data=%h stall=%0d required all 0",
                         ram_en, ram_addr, mem_rvalid, mem_rdata, stall_cnt);
    end
    tick();
    checks++;
    if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL midflight_late_rvalid: got %b required 0", mem_rvalid); end
    tick();
  endtask

  task automatic test_saturation();
    dbg_req = 1; dbg_we = 0; dbg_addr = 0;
    if_req = 1; if_addr = 1;
    for (int i = 0; i < 20; i++) begin
      #2;
      checks++;
      if (dbg_gnt !== 1'b1 || if_gnt !== 1'b0 || if_stall !== 1'b1) begin
        errors++; $display("FAIL sat_cycle%0d: got dbg=%b if=%b stall=%b required 1 0 1", i, dbg_gnt, if_gnt, if_stall);
      end
      tick();
    end
    checks++;
    if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cw4: got %0d required 15", s_stall_cnt); end
    checks++;
    if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cw16: got %0d required 20", stall_cnt); end
    clear_reqs();
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clear_reqs();
    test_reset();
    test_fetch();
    test_conflict();
    test_starvation();
    test_dbg_priority();
    test_reset_midflight();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port arbiter for the unified instruction/data memory of the pipe_MIPS32 core.
- Shares one synchronous RAM port between three requesters: debug/loader (dbg), MEM-stage load/store (mem) and IF-stage fetch (if).
- Generates the IF stall that the pipeline control uses to freeze PC/IF_ID.
- Includes a starvation guard so fetch cannot be blocked indefinitely by back-to-back data accesses.

Parameters:
- AW, 10, word-address width (RAM depth 2^AW words).
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive denied IF cycles after which IF outranks mem for one grant.
- CW, 16, width of the saturating stall statistics counter.

Ports:
- clk1  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- dbg_req  in  1  debug/loader access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  word address.
- dbg_wdata  in  DW  write data.
- dbg_gnt  out  1  combinational grant, same cycle as the request.
- dbg_rvalid  out  1  read data valid.
- dbg_rdata  out  DW  read data.
- mem_req, mem_we, mem_addr, mem_wdata  in  1/1/AW/DW  MEM-stage access, same meaning as the dbg_* inputs.
- mem_gnt, mem_rvalid, mem_rdata  out  1/1/DW  same meaning as the dbg_* outputs.
- if_req  in  1  fetch request (read only).
- if_addr  in  AW  fetch address.
- if_gnt, if_rvalid, if_rdata  out  1/1/DW  fetch grant, valid, data.
- if_stall  out  1  = if_req & ~if_gnt (combinational).
- ram_en  out  1  RAM access enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  AW  RAM address (registered).
- ram_wdata  out  DW  RAM write data (registered).
- ram_rdata  in  DW  RAM read data, valid one cycle after ram_en.
- stall_cnt  out  CW  saturating count of cycles with if_stall = 1.

Behaviour:
- Arbitration is combinational within cycle N. Exactly one gnt or none; a gnt is only asserted when its req is high.
- Priority order: dbg > mem > if.
- Starvation override: when starve_cnt == STARVE_LIMIT, if > mem. dbg still wins.
- starve_cnt:
  - Increments when if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on if_gnt or when if_req=0.
- Requester handshake: the request is consumed at the clk1 edge ending cycle N when gnt=1. The requester may present a new request in N+1.
- Cycle N+1: ram_en=1, ram_we/addr/wdata driven from the granted request. ram_en=0 when there was no grant.
- Cycle N+2 (reads only): the granted requester's rvalid=1 for exactly one cycle, with rdata = ram_rdata. Writes produce no rvalid.
- Read latency is 2 cycles from request to data. Throughput is one access per cycle; back-to-back grants are allowed.
- A 2-stage owner/read-tag pipeline routes ram_rdata to the correct requester. Non-owner rdata outputs hold 0.
- Ordering: accesses reach RAM in grant order. A write granted at N followed by a read of the same address at N+1 returns the new data, since the RAM is written before the read is issued.
- stall_cnt increments every cycle if_stall=1 and saturates at 2^CW-1.
- Reset: all registered outputs go to 0 (ram_en, ram_we, ram_addr, ram_wdata, every rvalid/rdata, stall_cnt, starve_cnt), and the in-flight owner pipeline is cleared.
  - A read granted in the cycle rst is asserted, or still in flight, yields no rvalid.
  - Grants are suppressed (all gnt=0) while rst=1.

Test Plan:
- Fetch only: if_req=1 with if_addr=0,1,2 on consecutive cycles, RAM preloaded with 0x2801000a/0x28010014/0x28010019 -> if_gnt=1 every cycle; if_rvalid on cycles 2,3,4 with those words in order; stall_cnt=0.
- Conflict: if_req and mem_req (read, addr 12, RAM[12]=0xfc000000) both high in one cycle -> mem_gnt=1, if_stall=1; mem_rvalid two cycles later with 0xfc000000; IF granted the next cycle; stall_cnt=1.
- Starvation: mem_req held high for 10 cycles with if_req high -> if_gnt on cycle 5 (after 4 denials); mem denied that cycle only; pattern repeats every 5 cycles.
- Debug priority: dbg write addr 5 = 0x00832800 together with mem_req and if_req -> dbg_gnt only. A mem read of addr 5 on the next grant returns 0x00832800.
- Reset mid-flight: mem read granted, rst=1 on the next cycle -> mem_rvalid never asserts; all outputs 0 after the edge; gnt=0 while rst=1.
- Saturation: with CW=4, hold if_stall for 20 cycles -> stall_cnt stops at 15.
